// File: rtl/deal_hands_pkg.sv
// Shared blackjack definitions: deal FSM states, hand geometry, card range and
// the random-generator reset value.
package deal_hands_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2
    } deal_state_t;

    localparam int          HAND_SLOTS = 9;
    localparam logic [3:0]  FULL_COUNT = 4'd9;
    localparam logic [3:0]  CARD_MIN   = 4'd1;
    localparam logic [3:0]  CARD_MAX   = 4'd13;
    localparam logic [15:0] LFSR_RESET = 16'hACE1;

    // Fibonacci LFSR step, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/deal_hands_lfsr.sv
// Free-running 16-bit card generator; a seed load overrides the step and an
// all-zero seed is replaced so the register can never lock up.
module card_lfsr
    import deal_hands_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;

    // Generator state: reset, seed load, or advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_RESET;
        end else if (load) begin
            r_lfsr <= (seed == 16'h0000) ? LFSR_RESET : seed;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign value = r_lfsr;

endmodule

// File: rtl/deal_hands.sv
// Blackjack card dealer: opening round of four cards and single-card hits,
// drawing card codes 1..13 from the LFSR with retry on out-of-range nibbles.
module deal_hands
    import deal_hands_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             new_round,
    input  logic                             hit_player,
    input  logic                             hit_dealer,
    input  logic                             seed_load,
    input  logic [15:0]                      seed,
    output logic [HAND_SLOTS-1:0][3:0]       player_card_values,
    output logic [HAND_SLOTS-1:0][3:0]       dealer_card_values,
    output logic [3:0]                       player_count,
    output logic [3:0]                       dealer_count,
    output logic                             busy,
    output logic                             deal_done,
    output logic                             hand_full
);

    deal_state_t                 r_state, w_state_nxt;
    logic [HAND_SLOTS-1:0][3:0]  r_player, w_player_nxt;
    logic [HAND_SLOTS-1:0][3:0]  r_dealer, w_dealer_nxt;
    logic [3:0]                  r_pcnt, w_pcnt_nxt;
    logic [3:0]                  r_dcnt, w_dcnt_nxt;
    logic                        r_round, w_round_nxt;
    logic                        r_target, w_target_nxt;
    logic [1:0]                  r_idx, w_idx_nxt;
    logic                        r_busy, r_deal_done, r_hand_full;
    logic                        w_deal_done_nxt, w_hand_full_nxt;
    logic [15:0]                 w_lfsr;
    logic [3:0]                  w_card;
    logic                        w_card_ok, w_to_dealer, w_last, w_unused_lfsr;

    card_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (seed_load),
        .seed  (seed),
        .value (w_lfsr)
    );

    assign w_card        = w_lfsr[3:0];
    assign w_unused_lfsr = ^w_lfsr[15:4];
    assign w_card_ok     = (w_card >= CARD_MIN) && (w_card <= CARD_MAX);
    // A round alternates player/dealer on the deal index; a hit has a fixed target.
    assign w_to_dealer   = r_round ? r_idx[0] : r_target;
    assign w_last        = !r_round || (r_idx == 2'd3);

    // Next-state, hand update and pulse generation.
    always_comb begin
        w_state_nxt     = r_state;
        w_player_nxt    = r_player;
        w_dealer_nxt    = r_dealer;
        w_pcnt_nxt      = r_pcnt;
        w_dcnt_nxt      = r_dcnt;
        w_round_nxt     = r_round;
        w_target_nxt    = r_target;
        w_idx_nxt       = r_idx;
        w_deal_done_nxt = 1'b0;
        w_hand_full_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (new_round) begin
                    w_state_nxt  = S_CLEAR;
                    w_player_nxt = '0;
                    w_dealer_nxt = '0;
                    w_pcnt_nxt   = 4'd0;
                    w_dcnt_nxt   = 4'd0;
                    w_round_nxt  = 1'b1;
                    w_idx_nxt    = 2'd0;
                end else if (hit_player) begin
                    if (r_pcnt >= FULL_COUNT) begin
                        w_hand_full_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_DRAW;
                        w_round_nxt  = 1'b0;
                        w_target_nxt = 1'b0;
                    end
                end else if (hit_dealer) begin
                    if (r_dcnt >= FULL_COUNT) begin
                        w_hand_full_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_DRAW;
                        w_round_nxt  = 1'b0;
                        w_target_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_DRAW;
            end
            S_DRAW: begin
                if (w_card_ok) begin
                    if (w_to_dealer) begin
                        if (r_dcnt < FULL_COUNT) begin
                            w_dealer_nxt[r_dcnt] = w_card;
                            w_dcnt_nxt           = r_dcnt + 4'd1;
                        end else begin
                            w_dcnt_nxt = r_dcnt;
                        end
                    end else begin
                        if (r_pcnt < FULL_COUNT) begin
                            w_player_nxt[r_pcnt] = w_card;
                            w_pcnt_nxt           = r_pcnt + 4'd1;
                        end else begin
                            w_pcnt_nxt = r_pcnt;
                        end
                    end
                    if (w_last) begin
                        w_state_nxt     = S_IDLE;
                        w_deal_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + 2'd1;
                    end
                end else begin
                    w_state_nxt = S_DRAW;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any deal in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_player    <= '0;
            r_dealer    <= '0;
            r_pcnt      <= 4'd0;
            r_dcnt      <= 4'd0;
            r_round     <= 1'b0;
            r_target    <= 1'b0;
            r_idx       <= 2'd0;
            r_busy      <= 1'b0;
            r_deal_done <= 1'b0;
            r_hand_full <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_player    <= w_player_nxt;
            r_dealer    <= w_dealer_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_dcnt      <= w_dcnt_nxt;
            r_round     <= w_round_nxt;
            r_target    <= w_target_nxt;
            r_idx       <= w_idx_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_deal_done <= w_deal_done_nxt;
            r_hand_full <= w_hand_full_nxt;
        end
    end

    assign player_card_values = r_player;
    assign dealer_card_values = r_dealer;
    assign player_count       = r_pcnt;
    assign dealer_count       = r_dcnt;
    assign busy               = r_busy;
    assign deal_done          = r_deal_done;
    assign hand_full          = r_hand_full;

endmodule
